register_file: RTL and testbench

- Architectural register file with rename tags. It sits on the responder side of the reorder buffer's commit and dependency interface.
- Holds x0..x31 values. Each register also carries a busy flag and a producer ROB id.
- Accepts commits and new-dependency marks from the ROB.
- Answers two decoder operand lookups per cycle, each returning either a value or a ROB tag. For busy registers it forwards ready values through the ROB's value-query ports.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_if.sv | 52 +++++
 rtl/register_file_read_port.sv | 40 ++++
 rtl/register_file.sv | 117 +++++++++++
 tb/tb_register_file.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and types for the architectural register file.
package register_file_pkg;

    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ID_W      = 5;
    localparam int unsigned NUM_REGS      = 32;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]     xword_t;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// ROB commit/dependency, decoder lookup and ROB value-query signals.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT
);

    // ROB commit and rename side
    logic                    clear;
    reg_id_t                 set_reg_id;
    xword_t                  set_val;
    logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id;
    reg_id_t                 set_dep_reg_id;
    logic [ROB_SIZE_BIT-1:0] set_dep_rob_id;

    // Decoder operand lookups
    reg_id_t                 get_id1;
    reg_id_t                 get_id2;
    xword_t                  val1;
    logic                    has_dep1;
    logic [ROB_SIZE_BIT-1:0] dep1;
    xword_t                  val2;
    logic                    has_dep2;
    logic [ROB_SIZE_BIT-1:0] dep2;

    // ROB value queries for busy operands
    logic [ROB_SIZE_BIT-1:0] get_rob_id1;
    logic                    rob_value1_ready;
    xword_t                  rob_value1;
    logic [ROB_SIZE_BIT-1:0] get_rob_id2;
    logic                    rob_value2_ready;
    xword_t                  rob_value2;

    // ROB/decoder side
    modport master (
        output clear, set_reg_id, set_val, set_reg_on_rob_id,
               set_dep_reg_id, set_dep_rob_id, get_id1, get_id2,
               rob_value1_ready, rob_value1, rob_value2_ready, rob_value2,
        input  val1, has_dep1, dep1, val2, has_dep2, dep2,
               get_rob_id1, get_rob_id2
    );

    // Register file side
    modport slave (
        input  clear, set_reg_id, set_val, set_reg_on_rob_id,
               set_dep_reg_id, set_dep_rob_id, get_id1, get_id2,
               rob_value1_ready, rob_value1, rob_value2_ready, rob_value2,
        output val1, has_dep1, dep1, val2, has_dep2, dep2,
               get_rob_id1, get_rob_id2
    );

endinterface : register_file_if

// File: rtl/register_file_read_port.sv
// One operand lookup: priority mux between x0, same-cycle commit,
// architectural value, ROB-forwarded value and pending tag.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
    input  reg_id_t                 get_id_i,
    input  xword_t                  reg_val_i,
    input  logic                    reg_busy_i,
    input  logic [ROB_SIZE_BIT-1:0] reg_tag_i,
    input  logic                    commit_hit_i,
    input  xword_t                  commit_val_i,
    input  logic                    rob_ready_i,
    input  xword_t                  rob_value_i,
    output xword_t                  val_o,
    output logic                    has_dep_o,
    output logic [ROB_SIZE_BIT-1:0] dep_o
);

    // Lookup priority; dependency fields stay zero unless the operand is pending
    always_comb begin
        val_o     = '0;
        has_dep_o = 1'b0;
        dep_o     = '0;
        if (get_id_i == '0) begin
            val_o = '0;
        end else if (commit_hit_i) begin
            val_o = commit_val_i;
        end else if (!reg_busy_i) begin
            val_o = reg_val_i;
        end else if (rob_ready_i) begin
            val_o = rob_value_i;
        end else begin
            has_dep_o = 1'b1;
            dep_o     = reg_tag_i;
        end
    end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// Architectural register file x0..x31 with busy flags and producer ROB tags.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
    input logic             clk_in,
    input logic             rst_in,
    input logic             rdy_in,
    register_file_if.slave  bus
);

    xword_t                  val_q  [NUM_REGS];
    xword_t                  val_d  [NUM_REGS];
    logic                    busy_q [NUM_REGS];
    logic                    busy_d [NUM_REGS];
    logic [ROB_SIZE_BIT-1:0] tag_q  [NUM_REGS];
    logic [ROB_SIZE_BIT-1:0] tag_d  [NUM_REGS];

    logic commit_fire_c;
    logic dep_fire_c;
    logic commit_hit1_c;
    logic commit_hit2_c;

    // Qualified update strobes; a flush suppresses new renames
    assign commit_fire_c = rdy_in && (bus.set_reg_id != '0);
    assign dep_fire_c    = rdy_in && !bus.clear && (bus.set_dep_reg_id != '0);

    // Next-state: flush, then commit, then rename (rename wins on same register)
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            val_d[i]  = val_q[i];
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (rdy_in && bus.clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
        if (commit_fire_c) begin
            val_d[bus.set_reg_id] = bus.set_val;
            if (!bus.clear && busy_q[bus.set_reg_id]
                && (tag_q[bus.set_reg_id] == bus.set_reg_on_rob_id)) begin
                busy_d[bus.set_reg_id] = 1'b0;
            end
        end
        if (dep_fire_c) begin
            busy_d[bus.set_dep_reg_id] = 1'b1;
            tag_d[bus.set_dep_reg_id]  = bus.set_dep_rob_id;
        end
        val_d[0]  = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // State register with synchronous reset; holds everything while paused
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                val_q[i]  <= val_d[i];
                busy_q[i] <= busy_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    // Same-cycle commit bypass, unless the same register is being renamed now
    assign commit_hit1_c = commit_fire_c
        && (bus.set_reg_id == bus.get_id1)
        && (tag_q[bus.get_id1] == bus.set_reg_on_rob_id)
        && !(dep_fire_c && (bus.set_dep_reg_id == bus.get_id1));
    assign commit_hit2_c = commit_fire_c
        && (bus.set_reg_id == bus.get_id2)
        && (tag_q[bus.get_id2] == bus.set_reg_on_rob_id)
        && !(dep_fire_c && (bus.set_dep_reg_id == bus.get_id2));

    // ROB is always queried with the current producer tag
    assign bus.get_rob_id1 = tag_q[bus.get_id1];
    assign bus.get_rob_id2 = tag_q[bus.get_id2];

    register_file_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_port1 (
        .get_id_i     (bus.get_id1),
        .reg_val_i    (val_q[bus.get_id1]),
        .reg_busy_i   (busy_q[bus.get_id1]),
        .reg_tag_i    (tag_q[bus.get_id1]),
        .commit_hit_i (commit_hit1_c),
        .commit_val_i (bus.set_val),
        .rob_ready_i  (bus.rob_value1_ready),
        .rob_value_i  (bus.rob_value1),
        .val_o        (bus.val1),
        .has_dep_o    (bus.has_dep1),
        .dep_o        (bus.dep1)
    );

    register_file_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_port2 (
        .get_id_i     (bus.get_id2),
        .reg_val_i    (val_q[bus.get_id2]),
        .reg_busy_i   (busy_q[bus.get_id2]),
        .reg_tag_i    (tag_q[bus.get_id2]),
        .commit_hit_i (commit_hit2_c),
        .commit_val_i (bus.set_val),
        .rob_ready_i  (bus.rob_value2_ready),
        .rob_value_i  (bus.rob_value2),
        .val_o        (bus.val2),
        .has_dep_o    (bus.has_dep2),
        .dep_o        (bus.dep2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file with hand-computed expectations.
module tb_register_file;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    int   checks;
    int   failures;

    register_file_if #(.ROB_SIZE_BIT(4)) bus ();

    register_file #(.ROB_SIZE_BIT(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.clear             = 1'b0;
        bus.set_reg_id        = '0;
        bus.set_val           = '0;
        bus.set_reg_on_rob_id = '0;
        bus.set_dep_reg_id    = '0;
        bus.set_dep_rob_id    = '0;
        bus.rob_value1_ready  = 1'b0;
        bus.rob_value1        = '0;
        bus.rob_value2_ready  = 1'b0;
        bus.rob_value2        = '0;
    endtask

    task automatic rename(input logic [4:0] r, input logic [3:0] rob);
        bus.set_dep_reg_id = r;
        bus.set_dep_rob_id = rob;
        tick();
        bus.set_dep_reg_id = '0;
        bus.set_dep_rob_id = '0;
    endtask

    task automatic read1(input string tag, input logic [4:0] r,
                         input logic [31:0] v, input logic d, input logic [3:0] t);
        bus.get_id1 = r;
        #1;
        check_eq({tag, ".val1"},     bus.val1,           v);
        check_eq({tag, ".has_dep1"}, 32'(bus.has_dep1),  32'(d));
        check_eq({tag, ".dep1"},     32'(bus.dep1),      32'(t));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus.get_id1 = '0;
        bus.get_id2 = '0;
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state on both ports
        read1("rst_x5", 5'd5, 32'h0, 1'b0, 4'd0);
        bus.get_id2 = 5'd0;
        #1;
        check_eq("rst_x0.val2",     bus.val2,              32'h0);
        check_eq("rst_x0.has_dep2", 32'(bus.has_dep2),     32'h0);
        check_eq("rst_x5.rob_id1",  32'(bus.get_rob_id1),  32'h0);

        // Rename x5 to rob 3; port 2 forwards a ready ROB value
        rename(5'd5, 4'd3);
        read1("dep_x5", 5'd5, 32'h0, 1'b1, 4'd3);
        check_eq("dep_x5.rob_id1", 32'(bus.get_rob_id1), 32'd3);
        bus.get_id2          = 5'd5;
        bus.rob_value2_ready = 1'b1;
        bus.rob_value2       = 32'h0000_1234;
        #1;
        check_eq("fwd_x5.val2",     bus.val2,          32'h0000_1234);
        check_eq("fwd_x5.has_dep2", 32'(bus.has_dep2), 32'h0);
        idle();

        // Commit bypass, then register is no longer busy
        bus.set_reg_id        = 5'd5;
        bus.set_val           = 32'hDEAD_BEEF;
        bus.set_reg_on_rob_id = 4'd3;
        read1("cmt_bypass", 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);
        tick();
        idle();
        read1("cmt_after", 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);

        // Stale commit must not clear a newer rename
        rename(5'd5, 4'd3);
        rename(5'd5, 4'd7);
        bus.set_reg_id        = 5'd5;
        bus.set_val           = 32'h0000_0011;
        bus.set_reg_on_rob_id = 4'd3;
        read1("stale_same", 5'd5, 32'h0, 1'b1, 4'd7);
        tick();
        idle();
        read1("stale_after", 5'd5, 32'h0, 1'b1, 4'd7);
        check_eq("stale.rob_id1", 32'(bus.get_rob_id1), 32'd7);
        bus.rob_value1_ready = 1'b1;
        bus.rob_value1       = 32'h0000_0022;
        read1("stale_fwd", 5'd5, 32'h0000_0022, 1'b0, 4'd0);
        idle();

        // Commit and rename of x6 in one cycle: rename wins, value still written
        bus.set_reg_id        = 5'd6;
        bus.set_val           = 32'h0000_0066;
        bus.set_reg_on_rob_id = 4'd2;
        bus.set_dep_reg_id    = 5'd6;
        bus.set_dep_rob_id    = 4'd9;
        read1("cd_same", 5'd6, 32'h0, 1'b0, 4'd0);
        tick();
        idle();
        read1("cd_after", 5'd6, 32'h0, 1'b1, 4'd9);

        // Flush with a commit on x1 and an ignored rename on x7
        rename(5'd1, 4'd1);
        rename(5'd2, 4'd2);
        rename(5'd3, 4'd4);
        read1("pre_clr_x2", 5'd2, 32'h0, 1'b1, 4'd2);
        bus.clear             = 1'b1;
        bus.set_reg_id        = 5'd1;
        bus.set_val           = 32'h0000_0055;
        bus.set_reg_on_rob_id = 4'd1;
        bus.set_dep_reg_id    = 5'd7;
        bus.set_dep_rob_id    = 4'd5;
        read1("clr_bypass", 5'd1, 32'h0000_0055, 1'b0, 4'd0);
        tick();
        idle();
        read1("clr_x1", 5'd1, 32'h0000_0055, 1'b0, 4'd0);
        read1("clr_x2", 5'd2, 32'h0, 1'b0, 4'd0);
        check_eq("clr_x2.rob_id1", 32'(bus.get_rob_id1), 32'h0);
        read1("clr_x3", 5'd3, 32'h0, 1'b0, 4'd0);
        read1("clr_x5", 5'd5, 32'h0000_0011, 1'b0, 4'd0);
        read1("clr_x6", 5'd6, 32'h0000_0066, 1'b0, 4'd0);
        read1("clr_x7", 5'd7, 32'h0, 1'b0, 4'd0);

        // Paused: commit and rename are both blocked
        rdy_in                = 1'b0;
        bus.set_reg_id        = 5'd1;
        bus.set_val           = 32'h0000_0099;
        bus.set_reg_on_rob_id = 4'd0;
        bus.set_dep_reg_id    = 5'd8;
        bus.set_dep_rob_id    = 4'd6;
        read1("pause_same", 5'd1, 32'h0000_0055, 1'b0, 4'd0);
        tick();
        tick();
        idle();
        rdy_in = 1'b1;
        read1("pause_x1", 5'd1, 32'h0000_0055, 1'b0, 4'd0);
        read1("pause_x8", 5'd8, 32'h0, 1'b0, 4'd0);

        // Mid-run reset wipes values and busy flags
        rename(5'd4, 4'd10);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        read1("rst2_x1", 5'd1, 32'h0, 1'b0, 4'd0);
        read1("rst2_x4", 5'd4, 32'h0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file
